// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the RAMHelper port arbiter.
// The byte-address to RAM-index mapping and the alignment rule live here.
package ram_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned INST_W = 32;
  localparam logic [ADDR_W-1:0] DEF_RAM_BASE = 64'h8000_0000;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_RESP  = 3'd2,
    ST_WR       = 3'd3,
    ST_ERR      = 3'd4
  } state_e;

  // Request captured at acceptance; fetches carry size W and no store data
  typedef struct packed {
    logic              fetch;
    logic [ADDR_W-1:0] addr;
    size_e             size;
    logic              uns;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic misaligned(input size_e size, input logic [2:0] lane);
    case (size)
      SZ_H:    return lane[0];
      SZ_W:    return |lane[1:0];
      SZ_D:    return |lane;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] ram_index(input logic [ADDR_W-1:0] addr,
                                                  input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] off;
    off = addr - base;
    return off >> 3;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_lane_align.sv
// Byte-lane alignment: shifts store data/mask into the 64-bit word and
// extracts plus sign/zero-extends load data from it.
module ram_port_arbiter_lane_align
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [2:0]  lane_i,
  input  logic        uns_i,
  input  logic [63:0] st_data_i,
  input  logic [63:0] ld_word_i,
  output logic [63:0] st_data_o,
  output logic [63:0] st_mask_o,
  output logic [63:0] ld_data_o
);

  logic [5:0]  shamt;
  logic [63:0] size_mask;
  logic [63:0] ld_shift;

  assign shamt     = {lane_i, 3'b000};
  assign ld_shift  = ld_word_i >> shamt;
  assign st_data_o = st_data_i << shamt;
  assign st_mask_o = size_mask << shamt;

  always_comb begin
    size_mask = '0;
    ld_data_o = '0;
    case (size_e'(size_i))
      SZ_B: begin
        size_mask = 64'h0000_0000_0000_00FF;
        ld_data_o = uns_i ? {56'b0, ld_shift[7:0]} : {{56{ld_shift[7]}}, ld_shift[7:0]};
      end
      SZ_H: begin
        size_mask = 64'h0000_0000_0000_FFFF;
        ld_data_o = uns_i ? {48'b0, ld_shift[15:0]} : {{48{ld_shift[15]}}, ld_shift[15:0]};
      end
      SZ_W: begin
        size_mask = 64'h0000_0000_FFFF_FFFF;
        ld_data_o = uns_i ? {32'b0, ld_shift[31:0]} : {{32{ld_shift[31]}}, ld_shift[31:0]};
      end
      SZ_D: begin
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        ld_data_o = ld_shift;
      end
      default: begin
        size_mask = '0;
        ld_data_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single RAMHelper port between instruction fetch and load/store.
// Data requests win over fetches; one transaction is in flight at a time.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RAM_BASE = DEF_RAM_BASE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_valid_i,
  output logic              if_req_ready_o,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_resp_valid_o,
  output logic [INST_W-1:0] if_resp_inst_o,
  input  logic              d_req_valid_i,
  output logic              d_req_ready_o,
  input  logic              d_req_we_i,
  input  logic [ADDR_W-1:0] d_req_addr_i,
  input  logic [1:0]        d_req_size_i,
  input  logic              d_req_unsigned_i,
  input  logic [DATA_W-1:0] d_req_wdata_i,
  output logic              d_resp_valid_o,
  output logic [DATA_W-1:0] d_resp_rdata_o,
  output logic              d_resp_err_o,
  output logic              ram_ren_o,
  output logic [ADDR_W-1:0] ram_ridx_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_widx_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [DATA_W-1:0] ram_wmask_o
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic              idle;
  logic              d_take;
  logic              if_take;
  logic [ADDR_W-1:0] req_idx;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] st_mask;
  logic [DATA_W-1:0] ld_data;

  assign idle           = (state_q == ST_IDLE);
  assign d_req_ready_o  = idle;
  assign if_req_ready_o = idle && !d_req_valid_i;
  assign d_take         = d_req_valid_i && d_req_ready_o;
  assign if_take        = if_req_valid_i && if_req_ready_o;
  assign req_idx        = ram_index(req_q.addr, RAM_BASE);

  ram_port_arbiter_lane_align u_align (
    .size_i    (req_q.size),
    .lane_i    (req_q.addr[2:0]),
    .uns_i     (req_q.uns),
    .st_data_i (req_q.wdata),
    .ld_word_i (ram_rdata_i),
    .st_data_o (st_data),
    .st_mask_o (st_mask),
    .ld_data_o (ld_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) req_q <= '0;
    else       req_q <= req_d;
  end

  // Next state and request capture
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (d_take) begin
          req_d.fetch = 1'b0;
          req_d.addr  = d_req_addr_i;
          req_d.size  = size_e'(d_req_size_i);
          req_d.uns   = d_req_unsigned_i;
          req_d.wdata = d_req_wdata_i;
          if (misaligned(size_e'(d_req_size_i), d_req_addr_i[2:0])) state_d = ST_ERR;
          else if (d_req_we_i)                                      state_d = ST_WR;
          else                                                      state_d = ST_RD_ISSUE;
        end else if (if_take) begin
          req_d.fetch = 1'b1;
          req_d.addr  = if_addr_i;
          req_d.size  = SZ_W;
          req_d.uns   = 1'b1;
          req_d.wdata = '0;
          state_d     = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_RESP;
      ST_RD_RESP:  state_d = ST_IDLE;
      ST_WR:       state_d = ST_IDLE;
      ST_ERR:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Strobes and responses decoded from the registered state
  always_comb begin
    if_resp_valid_o = 1'b0;
    if_resp_inst_o  = '0;
    d_resp_valid_o  = 1'b0;
    d_resp_rdata_o  = '0;
    d_resp_err_o    = 1'b0;
    ram_ren_o       = 1'b0;
    ram_ridx_o      = '0;
    ram_wen_o       = 1'b0;
    ram_widx_o      = '0;
    ram_wdata_o     = '0;
    ram_wmask_o     = '0;
    case (state_q)
      ST_RD_ISSUE: begin
        ram_ren_o  = 1'b1;
        ram_ridx_o = req_idx;
      end
      ST_RD_RESP: begin
        if (req_q.fetch) begin
          if_resp_valid_o = 1'b1;
          if_resp_inst_o  = req_q.addr[2] ? ram_rdata_i[63:32] : ram_rdata_i[31:0];
        end else begin
          d_resp_valid_o = 1'b1;
          d_resp_rdata_o = ld_data;
        end
      end
      ST_WR: begin
        ram_wen_o      = 1'b1;
        ram_widx_o     = req_idx;
        ram_wdata_o    = st_data;
        ram_wmask_o    = st_mask;
        d_resp_valid_o = 1'b1;
      end
      ST_ERR: begin
        d_resp_valid_o = 1'b1;
        d_resp_err_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAMHelper model, transaction-level reference,
// per-cycle compare, directed literal cases and randomized traffic.
module tb_ram_port_arbiter;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_addr;
  logic [31:0] if_resp_inst;
  logic        d_req_valid, d_req_ready, d_req_we, d_req_unsigned;
  logic [63:0] d_req_addr, d_req_wdata;
  logic [1:0]  d_req_size;
  logic        d_resp_valid, d_resp_err;
  logic [63:0] d_resp_rdata;
  logic        ram_ren, ram_wen;
  logic [63:0] ram_ridx, ram_rdata, ram_widx, ram_wdata, ram_wmask;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .if_req_valid_i   (if_req_valid),
    .if_req_ready_o   (if_req_ready),
    .if_addr_i        (if_addr),
    .if_resp_valid_o  (if_resp_valid),
    .if_resp_inst_o   (if_resp_inst),
    .d_req_valid_i    (d_req_valid),
    .d_req_ready_o    (d_req_ready),
    .d_req_we_i       (d_req_we),
    .d_req_addr_i     (d_req_addr),
    .d_req_size_i     (d_req_size),
    .d_req_unsigned_i (d_req_unsigned),
    .d_req_wdata_i    (d_req_wdata),
    .d_resp_valid_o   (d_resp_valid),
    .d_resp_rdata_o   (d_resp_rdata),
    .d_resp_err_o     (d_resp_err),
    .ram_ren_o        (ram_ren),
    .ram_ridx_o       (ram_ridx),
    .ram_rdata_i      (ram_rdata),
    .ram_wen_o        (ram_wen),
    .ram_widx_o       (ram_widx),
    .ram_wdata_o      (ram_wdata),
    .ram_wmask_o      (ram_wmask)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // RAMHelper: registered read, masked write
  logic [63:0] ram [16];
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= ram[ram_ridx[3:0]];
    if (!preload && ram_wen)
      ram[ram_widx[3:0]] = (ram[ram_widx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
  end

  // Reference model: one transaction at a time, outputs scheduled by cycle
  typedef struct packed {
    logic        ren;
    logic [63:0] ridx;
    logic        wen;
    logic [63:0] widx;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic        ifv;
    logic [31:0] inst;
    logic        dv;
    logic [63:0] rdata;
    logic        err;
  } want_t;

  want_t       want_q [8];
  logic [63:0] mm [16];
  int          cyc = 0;
  int          free_at = 0;
  bit          started = 1'b0;

  always @(posedge clk) begin : model
    int          k, lane, n;
    logic [63:0] off, w, val, mask, wsh;
    logic [3:0]  ix;
    want_t       e1, e2;
    k  = cyc + 1;
    e1 = '0;
    e2 = '0;
    if (rst) begin
      for (int i = 0; i < 8; i++) want_q[i] = '0;
      free_at = k;
      started = 1'b1;
    end else if (started && cyc >= free_at) begin
      if (d_req_valid) begin
        off  = d_req_addr - BASE;
        ix   = off[6:3];
        lane = int'(d_req_addr[2:0]);
        n    = 1 << int'(d_req_size);
        if ((lane % n) != 0) begin
          e1.dv  = 1'b1;
          e1.err = 1'b1;
          want_q[k % 8] = e1;
          free_at = k + 1;
        end else if (d_req_we) begin
          mask = '0;
          for (int b = 0; b < 8; b++)
            if (b >= lane && b < lane + n) mask[8*b +: 8] = 8'hFF;
          wsh = d_req_wdata << (8 * lane);
          mm[ix] = (mm[ix] & ~mask) | (wsh & mask);
          e1.wen   = 1'b1;
          e1.widx  = 64'(ix);
          e1.wdata = wsh;
          e1.wmask = mask;
          e1.dv    = 1'b1;
          want_q[k % 8] = e1;
          free_at = k + 1;
        end else begin
          w   = mm[ix];
          val = '0;
          for (int i = 0; i < n; i++) val[8*i +: 8] = w[8*(lane+i) +: 8];
          if (!d_req_unsigned && val[8*n-1])
            for (int i = n; i < 8; i++) val[8*i +: 8] = 8'hFF;
          e1.ren   = 1'b1;
          e1.ridx  = 64'(ix);
          e2.dv    = 1'b1;
          e2.rdata = val;
          want_q[k % 8]       = e1;
          want_q[(k + 1) % 8] = e2;
          free_at = k + 2;
        end
      end else if (if_req_valid) begin
        off  = if_addr - BASE;
        ix   = off[6:3];
        w    = mm[ix];
        e1.ren  = 1'b1;
        e1.ridx = 64'(ix);
        e2.ifv  = 1'b1;
        e2.inst = if_addr[2] ? w[63:32] : w[31:0];
        want_q[k % 8]       = e1;
        want_q[(k + 1) % 8] = e2;
        free_at = k + 2;
      end
    end
    cyc = k;
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin : compare
    want_t e;
    logic  busy;
    if (started) begin
      e    = want_q[cyc % 8];
      busy = (cyc < free_at);
      chk("d_req_ready",   64'(d_req_ready),   64'(!busy));
      chk("if_req_ready",  64'(if_req_ready),  64'(!busy && !d_req_valid));
      chk("ram_ren",       64'(ram_ren),       64'(e.ren));
      chk("ram_ridx",      ram_ridx,           e.ridx);
      chk("ram_wen",       64'(ram_wen),       64'(e.wen));
      chk("ram_widx",      ram_widx,           e.widx);
      chk("ram_wdata",     ram_wdata,          e.wdata);
      chk("ram_wmask",     ram_wmask,          e.wmask);
      chk("if_resp_valid", 64'(if_resp_valid), 64'(e.ifv));
      chk("if_resp_inst",  64'(if_resp_inst),  64'(e.inst));
      chk("d_resp_valid",  64'(d_resp_valid),  64'(e.dv));
      chk("d_resp_rdata",  d_resp_rdata,       e.rdata);
      chk("d_resp_err",    64'(d_resp_err),    64'(e.err));
      want_q[cyc % 8] = '0;
    end
  end

  task automatic issue_data(input logic we, input logic [63:0] addr, input logic [1:0] size,
                            input logic uns, input logic [63:0] wdata);
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr;
    d_req_size = size; d_req_unsigned = uns; d_req_wdata = wdata;
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    #1;
  endtask

  task automatic issue_fetch(input logic [63:0] addr);
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_addr = addr;
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    #1;
  endtask

  task automatic load_lit(input string name, input logic [63:0] addr, input logic uns,
                          input logic [63:0] want);
    issue_data(1'b0, addr, 2'd0, uns, 64'h0);
    @(posedge clk); #2;
    chk({name, "_valid"}, 64'(d_resp_valid), 64'd1);
    chk({name, "_rdata"}, d_resp_rdata, want);
  endtask

  initial begin
    int d_cyc, i_cyc;
    rst = 1'b1;
    if_req_valid = 1'b0; if_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_size = '0;
    d_req_unsigned = 1'b0; d_req_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      ram[i] = {$urandom, $urandom};
    end
    ram[0] = 64'h1111_2222_3333_4444;
    ram[2] = 64'h0000_0000_80FF_0000;
    for (int i = 0; i < 16; i++) mm[i] = ram[i];
    preload = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_d_ready",  64'(d_req_ready),  64'd1);
    chk("rst_if_ready", 64'(if_req_ready), 64'd1);
    chk("rst_strobes",  64'({ram_ren, ram_wen, if_resp_valid, d_resp_valid, d_resp_err}), 64'd0);
    chk("rst_buses",    ram_ridx | ram_widx | ram_wdata | ram_wmask | d_resp_rdata, 64'd0);
    rst = 1'b0;

    // Fetch from upper half of RAM[0]
    issue_fetch(64'h8000_0004);
    chk("fetch_ren_n1",  64'(ram_ren),  64'd1);
    chk("fetch_ridx_n1", ram_ridx,      64'd0);
    @(posedge clk); #2;
    chk("fetch_valid_n2", 64'(if_resp_valid), 64'd1);
    chk("fetch_inst_n2",  64'(if_resp_inst),  64'h1111_2222);
    chk("fetch_ren_n2",   64'(ram_ren),       64'd0);

    // Byte loads from RAM[2]: lane 2 holds FF, lane 3 holds 80
    load_lit("lb_12",  64'h8000_0012, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    load_lit("lbu_12", 64'h8000_0012, 1'b1, 64'h0000_0000_0000_00FF);
    load_lit("lb_13",  64'h8000_0013, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    load_lit("lbu_13", 64'h8000_0013, 1'b1, 64'h0000_0000_0000_0080);

    // Halfword store into lane 2 of RAM[1]
    issue_data(1'b1, 64'h8000_000A, 2'd1, 1'b0, 64'h0000_0000_0000_BEEF);
    chk("sh_wen",   64'(ram_wen),        64'd1);
    chk("sh_widx",  ram_widx,            64'd1);
    chk("sh_wmask", ram_wmask,           64'h0000_0000_FFFF_0000);
    chk("sh_wdata", 64'(ram_wdata[31:16]), 64'hBEEF);
    chk("sh_resp",  64'(d_resp_valid),   64'd1);

    // Misaligned word load
    issue_data(1'b0, 64'h8000_0002, 2'd2, 1'b0, 64'h0);
    chk("lw_mis_err",   64'(d_resp_err),     64'd1);
    chk("lw_mis_valid", 64'(d_resp_valid),   64'd1);
    chk("lw_mis_rdata", d_resp_rdata,        64'd0);
    chk("lw_mis_strb",  64'({ram_ren, ram_wen}), 64'd0);

    // Simultaneous fetch and load: load first, fetch 3 cycles later
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 64'h8000_0008;
    d_req_size = 2'd3; d_req_unsigned = 1'b0;
    if_req_valid = 1'b1; if_addr = 64'h8000_0000;
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    d_cyc = -1; i_cyc = -1;
    for (int t = 0; t < 12; t++) begin
      #1;
      if (d_resp_valid && d_cyc < 0) d_cyc = t;
      if (if_resp_valid) begin
        i_cyc = t;
        if_req_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if_req_valid = 1'b0;
    chk("both_load_latency", 64'(d_cyc), 64'd1);
    chk("both_fetch_gap",    64'(i_cyc - d_cyc), 64'd3);

    // Reset while the load is in RD_ISSUE
    issue_data(1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'h0);
    chk("rst_mid_ren", 64'(ram_ren), 64'd1);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("rst_mid_dv",    64'(d_resp_valid), 64'd0);
    chk("rst_mid_ren2",  64'(ram_ren),      64'd0);
    chk("rst_mid_ready", 64'({d_req_ready, if_req_ready}), 64'd3);
    rst = 1'b0;

    // Randomized mixed traffic
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rst            = ($urandom_range(63) == 0);
      d_req_valid    = ($urandom_range(1) == 1);
      d_req_we       = ($urandom_range(1) == 1);
      d_req_addr     = BASE + 64'($urandom_range(127));
      d_req_size     = 2'($urandom_range(3));
      d_req_unsigned = ($urandom_range(1) == 1);
      d_req_wdata    = {$urandom, $urandom};
      if_req_valid   = ($urandom_range(1) == 1);
      if_addr        = BASE + 64'($urandom_range(127));
    end
    @(posedge clk); #1;
    rst = 1'b0; d_req_valid = 1'b0; if_req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
